nios2_system_onchip_mem_arbiter: RTL and testbench
==================================================

// Module: nios2_system_onchip_mem_arbiter
// PURPOSE
//  Two-master round-robin arbiter in front of the single-port 16-bit on-chip memory.
//  m0 = Nios II instruction master, m1 = data master (or DMA); one memory access per cycle.
//  Tracks in-flight reads through the memory's fixed read latency and returns readdatavalid.
//  Suppresses accesses beyond the populated depth.
// PARAMETERS
//  ADDR_W        11    word address width, both slave ports and memory port
//  DATA_W        16    data width
//  BE_W          2     byteenable width (DATA_W/8)
//  MEM_WORDS     1860  populated words; addresses >= MEM_WORDS are out of range
//  READ_LATENCY  1     memory cycles from address to valid readdata (>=1)
// PORTS
//  clk               in   1       system clock
//  reset             in   1       synchronous, active-high reset
//  m{0,1}_address    in   ADDR_W  word address
//  m{0,1}_byteenable in   BE_W    byte lanes for writes
//  m{0,1}_read       in   1       read request
//  m{0,1}_write      in   1       write request (read&write together is illegal; write wins)
//  m{0,1}_writedata  in   DATA_W  write data
//  m{0,1}_waitrequest out 1       1 = request not accepted this cycle
//  m{0,1}_readdata   out  DATA_W  read data, valid with readdatavalid
//  m{0,1}_readdatavalid out 1     one pulse per accepted read
//  mem_address       out  ADDR_W  to memory address
//  mem_byteenable    out  BE_W    to memory byteenable
//  mem_chipselect    out  1       to memory chipselect
//  mem_write         out  1       to memory write
//  mem_writedata     out  DATA_W  to memory writedata
//  mem_clken         out  1       tied 1
//  mem_reset_req     out  1       = reset
//  mem_readdata      in   DATA_W  from memory (valid READ_LATENCY cycles after address)
// BEHAVIOUR
//  - Reset: last_grant<=1 (m0 has priority first), read pipeline cleared; all readdatavalid=0;
//    waitrequest=1 on both ports during reset; mem_chipselect=0, mem_write=0.
//  - Request mX = mX_read|mX_write. Grant is combinational from requests + last_grant:
//    only one requesting -> it wins; both -> the one != last_grant wins. last_grant<=winner at clk.
//  - Winner: waitrequest=0 same cycle; loser/idle: waitrequest=1. Worst-case wait 1 cycle.
//  - Memory port driven combinationally from winner; no request -> mem_chipselect=0, mem_write=0.
//  - Write: completes in grant cycle; no response.
//  - Read: shift register of {valid,id,oor} depth READ_LATENCY; entry pushed on granted read.
//    At output stage: readdatavalid pulses on port id, readdata=mem_readdata (0x0000 if oor).
//    Non-selected port readdata holds last value; readdatavalid=0.
//  - Out of range (address >= MEM_WORDS): write accepted, mem_chipselect=0 (dropped);
//    read accepted, mem_chipselect=0, returns 0x0000 on normal schedule.
//  - Back-to-back reads from both masters: one per cycle, responses in grant order, no gaps.
//  - Reset mid-read: in-flight entries discarded; no readdatavalid in the cycle after reset.
//  - read&write both high: treated as write, no read response.
// STRUCTURE
//  - Shared package: ADDR_W/DATA_W defaults, master-id constants M0=0/M1=1, rd-tracking
//    entry struct {valid, id, oor}.
//  - One sub-module: nios2_system_rr_arb2 (2-way round-robin grant + last_grant register).
//  - Read tracker is inline shift register in the top.
// TESTING
//  - Reset: assert reset 3 cycles with both requesting -> waitrequest=1, no mem_chipselect, no rdv.
//  - m0 write 0x0010<-0xBEEF be=2'b11, then m1 read 0x0010 -> m1_rdv 1 cycle later, data 0xBEEF.
//  - Both read every cycle, 8 cycles -> grants alternate m0,m1,...; each gets 4 rdv, in order.
//  - Byte write be=2'b01 data 0x12AB to 0xBEEF word -> readback 0xBEAB.
//  - Read addr 1860 and write addr 2000 -> mem_chipselect=0; read returns 0x0000 with rdv.
//  - Reset asserted cycle after granted read -> no readdatavalid emitted; next read is normal.

Source files
------------

// File: rtl/nios2_system_onchip_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios2_system_onchip_mem_arbiter_pkg
// Description : Shared widths, master ids and read-tracking entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package nios2_system_onchip_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 16;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
        logic oor;
    } rd_entry_t;

endpackage
`default_nettype wire

// File: rtl/nios2_system_onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : nios2_system_onchip_mem_arbiter_if
// Description : Avalon-MM style slave port between one master and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface nios2_system_onchip_mem_arbiter_if
    import nios2_system_onchip_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DATA_W / 8
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/nios2_system_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : nios2_system_rr_arb2
// Description : Two-way round-robin grant with registered last-grant pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_system_rr_arb2
    import nios2_system_onchip_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);
    logic r_last_grant;
    logic w_winner;

    // Contention goes to whoever was not served last; no grants while in reset.
    always_comb begin
        w_winner = ~r_last_grant;
        if (i_req == 2'b01) begin
            w_winner = M0;
        end else if (i_req == 2'b10) begin
            w_winner = M1;
        end
        o_grant = 2'b00;
        if (!rst && (|i_req)) begin
            o_grant = (w_winner == M1) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= M1;
        end else if (|o_grant) begin
            r_last_grant <= w_winner;
        end
    end
endmodule
`default_nettype wire

// File: rtl/nios2_system_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nios2_system_onchip_mem_arbiter
// Description : Round-robin arbiter for two masters sharing one on-chip RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_system_onchip_mem_arbiter
    import nios2_system_onchip_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BE_W         = DATA_W / 8,
    parameter int MEM_WORDS    = 1860,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    nios2_system_onchip_mem_arbiter_if.slave m0,
    nios2_system_onchip_mem_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [BE_W-1:0]       mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    output logic                  mem_reset_req,
    input  logic [DATA_W-1:0]     mem_readdata
);
    localparam logic [ADDR_W:0] c_mem_words = (ADDR_W + 1)'(MEM_WORDS);

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_any;
    logic              w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_is_write;
    logic              w_is_read;
    logic              w_oor;
    rd_entry_t         w_push;
    rd_entry_t         w_out;
    rd_entry_t         r_pipe [READ_LATENCY];
    logic              w_rdv0;
    logic              w_rdv1;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] r_hold0;
    logic [DATA_W-1:0] r_hold1;

    assign w_req = {m1.read | m1.write, m0.read | m0.write};

    nios2_system_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (reset),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    assign w_any = |w_grant;
    assign w_sel = w_grant[1];

    always_comb begin
        if (w_sel == M1) begin
            w_addr     = m1.address;
            w_be       = m1.byteenable;
            w_wdata    = m1.writedata;
            w_is_write = m1.write;
            w_is_read  = m1.read;
        end else begin
            w_addr     = m0.address;
            w_be       = m0.byteenable;
            w_wdata    = m0.writedata;
            w_is_write = m0.write;
            w_is_read  = m0.read;
        end
    end

    // Out-of-range accesses are accepted but never reach the RAM.
    assign w_oor          = ({1'b0, w_addr} >= c_mem_words);
    assign mem_address    = w_addr;
    assign mem_byteenable = w_be;
    assign mem_writedata  = w_wdata;
    assign mem_chipselect = w_any & ~w_oor;
    assign mem_write      = w_any & w_is_write & ~w_oor;
    assign mem_clken      = 1'b1;
    assign mem_reset_req  = reset;

    assign m0.waitrequest = ~w_grant[0];
    assign m1.waitrequest = ~w_grant[1];

    // Write has priority over read when both are raised, so no response then.
    assign w_push.valid = w_any & w_is_read & ~w_is_write;
    assign w_push.id    = w_sel;
    assign w_push.oor   = w_oor;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_push;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out   = r_pipe[READ_LATENCY-1];
    assign w_rdv0  = w_out.valid & ~reset & (w_out.id == M0);
    assign w_rdv1  = w_out.valid & ~reset & (w_out.id == M1);
    assign w_rdata = w_out.oor ? '0 : mem_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            if (w_rdv0) begin
                r_hold0 <= w_rdata;
            end
            if (w_rdv1) begin
                r_hold1 <= w_rdata;
            end
        end
    end

    assign m0.readdatavalid = w_rdv0;
    assign m1.readdatavalid = w_rdv1;
    assign m0.readdata      = w_rdv0 ? w_rdata : r_hold0;
    assign m1.readdata      = w_rdv1 ? w_rdata : r_hold1;
endmodule
`default_nettype wire

// File: tb/tb_nios2_system_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_system_onchip_mem_arbiter
// Description : Randomized self-checking bench with a behavioural arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_system_onchip_mem_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int WORDS = 1860;
    localparam int RL = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios2_system_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0_if ();
    nios2_system_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1_if ();

    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic          mem_clken;
    logic          mem_reset_req;
    logic [DW-1:0] mem_readdata = '0;

    nios2_system_onchip_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MEM_WORDS(WORDS), .READ_LATENCY(RL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_reset_req  (mem_reset_req),
        .mem_readdata   (mem_readdata)
    );

    // Single-port RAM with one cycle of read latency.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    function automatic logic [15:0] init_word(input int a);
        return 16'((a * 40503) ^ 23130);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int          due;
        int          port;
        logic [15:0] data;
    } resp_t;

    resp_t         exp_q[$];
    logic [15:0]   shadow [2**AW];
    int            last_served = 1;
    int            cyc = 0;
    logic [15:0]   last_rd [2];
    bit            have_rd [2];

    logic          rq_rd [2];
    logic          rq_wr [2];
    logic [AW-1:0] rq_ad [2];
    logic [BW-1:0] rq_be [2];
    logic [DW-1:0] rq_wd [2];
    logic          a_wait [2];
    logic          a_rdv [2];
    logic [DW-1:0] a_rd [2];
    bit            e_v [2];
    logic [15:0]   e_d [2];
    int            winner;
    bit            in_rng;
    resp_t         r;

    always @(negedge clk) begin
        rq_rd[0] = m0_if.read;  rq_wr[0] = m0_if.write;  rq_ad[0] = m0_if.address;
        rq_be[0] = m0_if.byteenable; rq_wd[0] = m0_if.writedata;
        rq_rd[1] = m1_if.read;  rq_wr[1] = m1_if.write;  rq_ad[1] = m1_if.address;
        rq_be[1] = m1_if.byteenable; rq_wd[1] = m1_if.writedata;
        a_wait[0] = m0_if.waitrequest; a_rdv[0] = m0_if.readdatavalid; a_rd[0] = m0_if.readdata;
        a_wait[1] = m1_if.waitrequest; a_rdv[1] = m1_if.readdatavalid; a_rd[1] = m1_if.readdata;

        chk("mem_clken", mem_clken, 1);
        chk("mem_reset_req", mem_reset_req, reset);
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                chk("reset_waitrequest", a_wait[p], 1);
                chk("reset_readdatavalid", a_rdv[p], 0);
                have_rd[p] = 0;
            end
            chk("reset_chipselect", mem_chipselect, 0);
            chk("reset_mem_write", mem_write, 0);
            exp_q.delete();
            last_served = 1;
        end else begin
            winner = -1;
            if ((rq_rd[0] | rq_wr[0]) && (rq_rd[1] | rq_wr[1])) winner = 1 - last_served;
            else if (rq_rd[0] | rq_wr[0]) winner = 0;
            else if (rq_rd[1] | rq_wr[1]) winner = 1;

            e_v[0] = 0; e_v[1] = 0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                r = exp_q.pop_front();
                e_v[r.port] = 1;
                e_d[r.port] = r.data;
            end

            for (int p = 0; p < 2; p++) begin
                chk("waitrequest", a_wait[p], (winner != p));
                chk("readdatavalid", a_rdv[p], e_v[p]);
                if (e_v[p]) begin
                    chk("readdata", a_rd[p], e_d[p]);
                    last_rd[p] = e_d[p];
                    have_rd[p] = 1;
                end else if (have_rd[p]) begin
                    chk("readdata_hold", a_rd[p], last_rd[p]);
                end
            end

            if (winner < 0) begin
                chk("idle_chipselect", mem_chipselect, 0);
                chk("idle_mem_write", mem_write, 0);
            end else begin
                in_rng = (int'(rq_ad[winner]) < WORDS);
                chk("mem_chipselect", mem_chipselect, in_rng);
                chk("mem_write", mem_write, in_rng && rq_wr[winner]);
                if (in_rng) chk("mem_address", mem_address, rq_ad[winner]);
                if (rq_wr[winner]) begin
                    if (in_rng) begin
                        chk("mem_writedata", mem_writedata, rq_wd[winner]);
                        chk("mem_byteenable", mem_byteenable, rq_be[winner]);
                        if (rq_be[winner][0]) shadow[rq_ad[winner]][7:0]  = rq_wd[winner][7:0];
                        if (rq_be[winner][1]) shadow[rq_ad[winner]][15:8] = rq_wd[winner][15:8];
                    end
                end else begin
                    exp_q.push_back('{due: cyc + RL, port: winner,
                                      data: in_rng ? shadow[rq_ad[winner]] : 16'h0000});
                end
                last_served = winner;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
        if (p == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = wd;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = wd;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
    endtask

    int n0, n1;
    int sel;
    logic [AW-1:0] ra;

    initial begin
        for (int a = 0; a < 2**AW; a++) begin
            ram[a]    = init_word(a);
            shadow[a] = init_word(a);
        end
        idle();
        reset = 1'b1;
        drive(0, 1, 0, 11'd5, 2'b11, '0);
        drive(1, 1, 0, 11'd6, 2'b11, '0);
        repeat (3) begin
            sample();
            chk("lit_reset_wait0", m0_if.waitrequest, 1);
            chk("lit_reset_wait1", m1_if.waitrequest, 1);
            chk("lit_reset_cs", mem_chipselect, 0);
            chk("lit_reset_rdv", {m0_if.readdatavalid, m1_if.readdatavalid}, 0);
            step();
        end
        reset = 1'b0;

        // full write then cross-master readback
        idle();
        drive(0, 0, 1, 11'h010, 2'b11, 16'hBEEF);
        sample();
        chk("lit_wr_wait0", m0_if.waitrequest, 0);
        chk("lit_wr_mem_write", mem_write, 1);
        chk("lit_wr_addr", mem_address, 11'h010);
        step();
        idle();
        drive(1, 1, 0, 11'h010, 2'b11, '0);
        sample();
        chk("lit_rd_wait1", m1_if.waitrequest, 0);
        step();
        idle();
        sample();
        chk("lit_rd_rdv1", m1_if.readdatavalid, 1);
        chk("lit_rd_data1", m1_if.readdata, 16'hBEEF);
        step();

        // both masters read every cycle: grants alternate starting with m0
        n0 = 0; n1 = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                drive(0, 1, 0, 11'(32 + i), 2'b11, '0);
                drive(1, 1, 0, 11'(64 + i), 2'b11, '0);
            end else begin
                idle();
            end
            sample();
            if (i < 8) chk("lit_alt_wait0", m0_if.waitrequest, i % 2);
            n0 += int'(m0_if.readdatavalid);
            n1 += int'(m1_if.readdatavalid);
            step();
        end
        chk("lit_alt_count0", n0, 4);
        chk("lit_alt_count1", n1, 4);

        // byte-lane write
        idle();
        drive(0, 0, 1, 11'h010, 2'b01, 16'h12AB);
        sample();
        step();
        drive(0, 1, 0, 11'h010, 2'b11, '0);
        sample();
        step();
        idle();
        sample();
        chk("lit_be_rdv0", m0_if.readdatavalid, 1);
        chk("lit_be_data0", m0_if.readdata, 16'hBEAB);
        step();

        // out-of-range accesses
        drive(1, 1, 0, 11'd1860, 2'b11, '0);
        sample();
        chk("lit_oor_rd_wait1", m1_if.waitrequest, 0);
        chk("lit_oor_rd_cs", mem_chipselect, 0);
        step();
        idle();
        drive(0, 0, 1, 11'd2000, 2'b11, 16'hFFFF);
        sample();
        chk("lit_oor_rdv1", m1_if.readdatavalid, 1);
        chk("lit_oor_data1", m1_if.readdata, 16'h0000);
        chk("lit_oor_wr_cs", mem_chipselect, 0);
        chk("lit_oor_wr_mw", mem_write, 0);
        step();

        // reset right after a granted read
        idle();
        drive(0, 1, 0, 11'h010, 2'b11, '0);
        sample();
        step();
        idle();
        reset = 1'b1;
        sample();
        chk("lit_rst_rdv0_a", m0_if.readdatavalid, 0);
        step();
        reset = 1'b0;
        sample();
        chk("lit_rst_rdv0_b", m0_if.readdatavalid, 0);
        step();
        drive(0, 1, 0, 11'h010, 2'b11, '0);
        sample();
        step();
        idle();
        sample();
        chk("lit_post_rst_rdv0", m0_if.readdatavalid, 1);
        chk("lit_post_rst_data0", m0_if.readdata, 16'hBEAB);
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < 2; p++) begin
                sel = $urandom_range(0, 9);
                if (sel < 7)       ra = 11'($urandom_range(0, 63));
                else if (sel == 7) ra = 11'($urandom_range(1855, 1865));
                else if (sel == 8) ra = 11'($urandom_range(0, 2047));
                else               ra = 11'h010;
                case ($urandom_range(0, 7))
                    0, 1:    drive(p, 0, 0, ra, 2'($urandom), 16'($urandom));
                    2, 3, 4: drive(p, 1, 0, ra, 2'($urandom), 16'($urandom));
                    5, 6:    drive(p, 0, 1, ra, 2'($urandom), 16'($urandom));
                    default: drive(p, 1, 1, ra, 2'($urandom), 16'($urandom));
                endcase
            end
            step();
        end
        reset = 1'b0;
        idle();
        repeat (4) step();
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
